multicycle_sequencer: RTL

//  Parametrised multicycle control unit for the RV32I core: decodes opcode into datapath controls and sequences

---
 rtl/multicycle_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multicycle control unit for the RV32I core. It decodes the opcode into datapath
//   controls and steps each instruction through IWAIT -> FETCH -> EXEC -> (MEM) -> COMMIT.
//   Wait states are configurable, the memory ready handshake is optional, stall freezes
//   the machine, and illegal opcodes or memory timeouts trap. A retired-instruction
//   counter is also kept.
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   opcode          instr[6:0] of the current instruction
//   br_en           branch condition from the comparator
//   stall           freezes state and counters; forces the strobes low
//   mem_ready       dmem transfer complete (only when USE_MEM_READY != 0)
//   imm_en, reg_wr_sel, pc_sel, mem_func
//                   decoded controls; they follow opcode in every state
//   fetch_instr, update_pc, reg_wr_en, mem_done, data_mem_wr_en
//                   per-state strobes
//   trap, trap_cause
//                   sticky trap flag and its cause (1 illegal, 2 mem timeout)
//   instret         count of retired instructions; it wraps
module multicycle_sequencer #(
    parameter int unsigned IMEM_WAIT     = 2,
    parameter int unsigned DMEM_WAIT     = 2,
    parameter int unsigned USE_MEM_READY = 0,
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             br_en,
    input  logic             stall,
    input  logic             mem_ready,
    output logic             imm_en,
    output logic             reg_wr_en,
    output logic [2:0]       reg_wr_sel,
    output logic             data_mem_wr_en,
    output logic [2:0]       pc_sel,
    output logic             mem_func,
    output logic             fetch_instr,
    output logic             update_pc,
    output logic             mem_done,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // A single wait counter serves IWAIT and MEM, so it is sized for the largest bound.
    localparam int unsigned WAIT_AB  = (IMEM_WAIT > DMEM_WAIT) ? IMEM_WAIT : DMEM_WAIT;
    localparam int unsigned WAIT_MAX = (WAIT_AB > MEM_TIMEOUT) ? WAIT_AB : MEM_TIMEOUT;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [WAIT_W-1:0] IMEM_LAST = WAIT_W'(IMEM_WAIT - 1);
    localparam logic [WAIT_W-1:0] DMEM_LAST = WAIT_W'(DMEM_WAIT - 1);
    localparam logic [WAIT_W-1:0] TOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IWAIT  = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_COMMIT = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_store;
    logic              dec_wr_en;
    logic              legal;

    // Opcode decode; it is combinational and independent of state.
    always_comb begin
        imm_en     = 1'b0;
        reg_wr_sel = 3'd0;
        pc_sel     = 3'd0;
        mem_func   = 1'b0;
        is_store   = 1'b0;
        dec_wr_en  = 1'b0;
        legal      = 1'b1;
        case (opcode)
            OP_IALU: begin
                imm_en    = 1'b1;
                dec_wr_en = 1'b1;
            end
            OP_R: begin
                dec_wr_en = 1'b1;
            end
            OP_LOAD: begin
                imm_en     = 1'b1;
                reg_wr_sel = 3'd1;
                mem_func   = 1'b1;
                dec_wr_en  = 1'b1;
            end
            OP_STORE: begin
                imm_en   = 1'b1;
                mem_func = 1'b1;
                is_store = 1'b1;
            end
            OP_BRANCH: begin
                pc_sel = br_en ? 3'd1 : 3'd0;
            end
            OP_JAL: begin
                reg_wr_sel = 3'd2;
                pc_sel     = 3'd4;
                dec_wr_en  = 1'b1;
            end
            OP_JALR: begin
                imm_en     = 1'b1;
                reg_wr_sel = 3'd2;
                pc_sel     = 3'd2;
                dec_wr_en  = 1'b1;
            end
            OP_LUI: begin
                reg_wr_sel = 3'd3;
                dec_wr_en  = 1'b1;
            end
            OP_AUIPC: begin
                reg_wr_sel = 3'd4;
                dec_wr_en  = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Strobes are a function of the current state. A stall must silence them in the
    // same cycle, so they cannot come from a register.
    always_comb begin
        fetch_instr    = 1'b0;
        update_pc      = 1'b0;
        reg_wr_en      = 1'b0;
        mem_done       = 1'b0;
        data_mem_wr_en = 1'b0;
        if (!stall) begin
            case (state)
                S_FETCH:  fetch_instr    = 1'b1;
                S_MEM:    data_mem_wr_en = is_store;
                S_COMMIT: begin
                    update_pc = 1'b1;
                    reg_wr_en = dec_wr_en;
                    mem_done  = mem_func;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, wait counter, trap record and retired count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IWAIT;
            wait_cnt   <= '0;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else if (!stall) begin
            case (state)
                S_IWAIT: begin
                    if (wait_cnt == IMEM_LAST) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_FETCH: begin
                    state    <= S_EXEC;
                    wait_cnt <= '0;
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (!legal) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else if (mem_func) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_MEM: begin
                    if (USE_MEM_READY != 0) begin
                        if (mem_ready) begin
                            state    <= S_COMMIT;
                            wait_cnt <= '0;
                        end else if (wait_cnt == TOUT_LAST) begin
                            state      <= S_TRAP;
                            trap       <= 1'b1;
                            trap_cause <= CAUSE_TIMEOUT;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        if (wait_cnt == DMEM_LAST) begin
                            state    <= S_COMMIT;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    instret  <= instret + CNT_W'(1);
                    state    <= S_IWAIT;
                    wait_cnt <= '0;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state    <= S_IWAIT;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
